// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause 22 MDIO PHY-side responder with a local register-bank port
module mdio_responder #(
    parameter int PRE_LEN  = 32,
    parameter bit BCAST_EN = 1'b0
) (
    input  logic        mdc,
    input  logic        rst_n,
    input  logic [4:0]  phy_addr,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST2,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RDATA,
        S_WDATA,
        S_SKIP
    } state_t;

    localparam logic [6:0] PRE_MIN = 7'(PRE_LEN);

    state_t      state, state_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [5:0]  pre_cnt, pre_cnt_n;
    logic        op_rd, op_rd_n;
    logic        match, match_n;
    logic [4:0]  addr_sh, addr_sh_n;
    logic [15:0] shift, shift_n;
    logic        mdio_o_n, mdio_oe_n;
    logic [4:0]  reg_addr_n;
    logic        reg_rd_n, reg_wr_n;
    logic [15:0] reg_wdata_n;
    logic        frame_err_n;
    logic [4:0]  addr_in;

    assign addr_in = {addr_sh[3:0], mdio_i};
    assign busy    = (state != S_IDLE);

    always_ff @(posedge mdc or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            op_rd     <= 1'b0;
            match     <= 1'b0;
            addr_sh   <= '0;
            shift     <= '0;
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            reg_addr  <= '0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            pre_cnt   <= pre_cnt_n;
            op_rd     <= op_rd_n;
            match     <= match_n;
            addr_sh   <= addr_sh_n;
            shift     <= shift_n;
            mdio_o    <= mdio_o_n;
            mdio_oe   <= mdio_oe_n;
            reg_addr  <= reg_addr_n;
            reg_rd    <= reg_rd_n;
            reg_wr    <= reg_wr_n;
            reg_wdata <= reg_wdata_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        pre_cnt_n   = pre_cnt;
        op_rd_n     = op_rd;
        match_n     = match;
        addr_sh_n   = addr_sh;
        shift_n     = shift;
        mdio_o_n    = mdio_o;
        mdio_oe_n   = mdio_oe;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_rd_n    = 1'b0;
        reg_wr_n    = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (mdio_i) begin
                    if (pre_cnt != 6'd63) pre_cnt_n = pre_cnt + 6'd1;
                end else if ({1'b0, pre_cnt} >= PRE_MIN) begin
                    // this zero is the first ST bit
                    state_n   = S_ST2;
                    pre_cnt_n = '0;
                end else begin
                    pre_cnt_n = '0;
                end
            end
            S_ST2: begin
                if (mdio_i) begin
                    state_n   = S_OP;
                    bit_cnt_n = '0;
                end else begin
                    frame_err_n = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            S_OP: begin
                // first OP bit is 1 for read (10), 0 for write (01); equal bits are illegal
                if (bit_cnt == 5'd0) begin
                    op_rd_n   = mdio_i;
                    bit_cnt_n = 5'd1;
                end else if (op_rd != mdio_i) begin
                    state_n   = S_PHYAD;
                    bit_cnt_n = '0;
                end else begin
                    frame_err_n = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            S_PHYAD: begin
                addr_sh_n = addr_in;
                bit_cnt_n = bit_cnt + 5'd1;
                if (bit_cnt == 5'd4) begin
                    match_n   = (addr_in == phy_addr) ||
                                (BCAST_EN && (addr_in == 5'd0) && !op_rd);
                    state_n   = S_REGAD;
                    bit_cnt_n = '0;
                end
            end
            S_REGAD: begin
                addr_sh_n = addr_in;
                bit_cnt_n = bit_cnt + 5'd1;
                if (bit_cnt == 5'd4) begin
                    bit_cnt_n = '0;
                    if (!match) begin
                        state_n = S_SKIP;
                    end else begin
                        reg_addr_n = addr_in;
                        reg_rd_n   = op_rd;
                        state_n    = S_TA;
                    end
                end
            end
            S_TA: begin
                if (op_rd) begin
                    // take over the line for the second turnaround slot
                    shift_n   = reg_rdata;
                    mdio_oe_n = 1'b1;
                    mdio_o_n  = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = S_RDATA;
                end else if (bit_cnt == 5'd0) begin
                    if (mdio_i) begin
                        bit_cnt_n = 5'd1;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_IDLE;
                    end
                end else if (!mdio_i) begin
                    bit_cnt_n = '0;
                    state_n   = S_WDATA;
                end else begin
                    frame_err_n = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            S_RDATA: begin
                if (bit_cnt == 5'd16) begin
                    mdio_oe_n = 1'b0;
                    mdio_o_n  = 1'b0;
                    state_n   = S_IDLE;
                end else begin
                    mdio_o_n  = shift[15];
                    shift_n   = {shift[14:0], 1'b0};
                    bit_cnt_n = bit_cnt + 5'd1;
                end
            end
            S_WDATA: begin
                shift_n   = {shift[14:0], mdio_i};
                bit_cnt_n = bit_cnt + 5'd1;
                if (bit_cnt == 5'd15) begin
                    reg_wdata_n = {shift[14:0], mdio_i};
                    reg_wr_n    = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            S_SKIP: begin
                bit_cnt_n = bit_cnt + 5'd1;
                if (bit_cnt == 5'd17) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - directed and randomized frames scored against a field-level responder model
module tb_mdio_responder;

    logic        mdc = 1'b0;
    logic        rst_n;
    logic        mdio;
    logic [4:0]  phy_addr [2];
    logic        mdio_o_w [2];
    logic        mdio_oe_w [2];
    logic [4:0]  reg_addr_w [2];
    logic        reg_rd_w [2];
    logic [15:0] reg_rdata_w [2];
    logic        reg_wr_w [2];
    logic [15:0] reg_wdata_w [2];
    logic        busy_w [2];
    logic        frame_err_w [2];
    logic [15:0] bank [32];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 mdc = ~mdc;

    assign reg_rdata_w[0] = bank[reg_addr_w[0]];
    assign reg_rdata_w[1] = bank[reg_addr_w[1]];

    mdio_responder #(.PRE_LEN(32), .BCAST_EN(1'b0)) dut (
        .mdc(mdc), .rst_n(rst_n), .phy_addr(phy_addr[0]), .mdio_i(mdio),
        .mdio_o(mdio_o_w[0]), .mdio_oe(mdio_oe_w[0]), .reg_addr(reg_addr_w[0]),
        .reg_rd(reg_rd_w[0]), .reg_rdata(reg_rdata_w[0]), .reg_wr(reg_wr_w[0]),
        .reg_wdata(reg_wdata_w[0]), .busy(busy_w[0]), .frame_err(frame_err_w[0])
    );

    mdio_responder #(.PRE_LEN(0), .BCAST_EN(1'b1)) dut_np (
        .mdc(mdc), .rst_n(rst_n), .phy_addr(phy_addr[1]), .mdio_i(mdio),
        .mdio_o(mdio_o_w[1]), .mdio_oe(mdio_oe_w[1]), .reg_addr(reg_addr_w[1]),
        .reg_rd(reg_rd_w[1]), .reg_rdata(reg_rdata_w[1]), .reg_wr(reg_wr_w[1]),
        .reg_wdata(reg_wdata_w[1]), .busy(busy_w[1]), .frame_err(frame_err_w[1])
    );

    // running observations, sampled mid-cycle
    int          m_rd [2] = '{0, 0};
    int          m_wr [2] = '{0, 0};
    int          m_err [2] = '{0, 0};
    int          m_oe [2] = '{0, 0};
    int          m_busy [2] = '{0, 0};
    int          m_ovl [2] = '{0, 0};
    logic [4:0]  m_rd_addr [2] = '{5'd0, 5'd0};
    logic [4:0]  m_wr_addr [2] = '{5'd0, 5'd0};
    logic [15:0] m_wdata [2] = '{16'd0, 16'd0};
    logic [16:0] m_rsp [2] = '{17'd0, 17'd0};

    always @(negedge mdc) begin
        for (int i = 0; i < 2; i++) begin
            if (reg_rd_w[i]) begin m_rd[i] += 1; m_rd_addr[i] = reg_addr_w[i]; end
            if (reg_wr_w[i]) begin
                m_wr[i] += 1; m_wr_addr[i] = reg_addr_w[i]; m_wdata[i] = reg_wdata_w[i];
            end
            if (frame_err_w[i]) m_err[i] += 1;
            if (busy_w[i]) m_busy[i] += 1;
            if ((reg_rd_w[i] && reg_wr_w[i]) || ((reg_rd_w[i] || reg_wr_w[i]) && frame_err_w[i]))
                m_ovl[i] += 1;
            if (mdio_oe_w[i]) begin m_oe[i] += 1; m_rsp[i] = {m_rsp[i][15:0], mdio_o_w[i]}; end
        end
    end

    int s_rd [2], s_wr [2], s_err [2], s_oe [2], s_busy [2], s_ovl [2];

    typedef struct {
        int          rd;
        int          wr;
        int          err;
        int          oe;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [16:0] rsp;
        bit          quiet;
    } exp_t;

    // what a Clause 22 PHY must do with one frame, judged from its fields alone
    function automatic exp_t model(input int idx, input int pre, input logic [1:0] st,
                                   input logic [1:0] op, input logic [4:0] pa,
                                   input logic [4:0] ra, input logic [1:0] ta,
                                   input logic [15:0] d);
        exp_t e;
        int   plen;
        bit   bc;
        e = '{default: 0};
        plen = (idx == 0) ? 32 : 0;
        bc = (idx == 1);
        if (pre < plen) begin e.quiet = 1'b1; return e; end
        if (st != 2'b01 || !(op == 2'b10 || op == 2'b01)) begin e.err = 1; return e; end
        if (!(pa == phy_addr[idx] || (bc && pa == 5'd0 && op == 2'b01))) return e;
        e.addr = ra;
        if (op == 2'b10) begin
            e.rd = 1; e.oe = 17; e.rsp = {1'b0, bank[ra]};
        end else if (ta != 2'b10) begin
            e.err = 1;
        end else begin
            e.wr = 1; e.wdata = d;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            s_rd[i] = m_rd[i]; s_wr[i] = m_wr[i]; s_err[i] = m_err[i];
            s_oe[i] = m_oe[i]; s_busy[i] = m_busy[i]; s_ovl[i] = m_ovl[i];
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge mdc);
        mdio = b;
    endtask

    task automatic send_frame(input int npre, input bit clr, input logic [1:0] st,
                              input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                              input logic [1:0] ta, input logic [15:0] d, input int ntail);
        if (clr) send_bit(1'b0);
        for (int i = 0; i < npre; i++) send_bit(1'b1);
        #1;
        snap();
        for (int i = 1; i >= 0; i--) send_bit(st[i]);
        for (int i = 1; i >= 0; i--) send_bit(op[i]);
        for (int i = 4; i >= 0; i--) send_bit(pa[i]);
        for (int i = 4; i >= 0; i--) send_bit(ra[i]);
        // master releases the line (pull-up reads 1) for the read turnaround and data
        for (int i = 0; i < ntail; i++)
            send_bit(op == 2'b10 ? 1'b1 : (i < 2 ? ta[1-i] : d[17-i]));
        send_bit(1'b1);
        #1;
    endtask

    task automatic check(input int idx, input exp_t e, input string tag);
        string p;
        p = $sformatf("%s/d%0d", tag, idx);
        chk({p, "/rd"}, m_rd[idx] - s_rd[idx], e.rd);
        chk({p, "/wr"}, m_wr[idx] - s_wr[idx], e.wr);
        chk({p, "/err"}, m_err[idx] - s_err[idx], e.err);
        chk({p, "/oe_cycles"}, m_oe[idx] - s_oe[idx], e.oe);
        chk({p, "/overlap"}, m_ovl[idx] - s_ovl[idx], 0);
        if (e.rd > 0) begin
            chk({p, "/rd_addr"}, m_rd_addr[idx], e.addr);
            chk({p, "/rsp"}, m_rsp[idx], e.rsp);
        end
        if (e.wr > 0) begin
            chk({p, "/wr_addr"}, m_wr_addr[idx], e.addr);
            chk({p, "/wdata"}, m_wdata[idx], e.wdata);
        end
        if (e.quiet) chk({p, "/busy"}, m_busy[idx] - s_busy[idx], 0);
    endtask

    task automatic run(input int mask, input int npre, input bit clr, input logic [1:0] st,
                       input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [1:0] ta, input logic [15:0] d, input string tag);
        int pre;
        send_frame(npre, clr, st, op, pa, ra, ta, d, 18);
        pre = clr ? npre : npre + 1;
        for (int i = 0; i < 2; i++)
            if (mask[i]) check(i, model(i, pre, st, op, pa, ra, ta, d), tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic [4:0]  pa;
        int          sel;

        rst_n = 1'b0;
        mdio = 1'b1;
        phy_addr[0] = 5'd1;
        phy_addr[1] = 5'd1;
        for (int i = 0; i < 32; i++) bank[i] = 16'($urandom);
        bank[2] = 16'hA5C3;
        repeat (3) @(negedge mdc);
        #1;
        chk("rst/mdio_oe", mdio_oe_w[0], 0);
        chk("rst/mdio_o", mdio_o_w[0], 0);
        chk("rst/reg_addr", reg_addr_w[0], 0);
        chk("rst/reg_wdata", reg_wdata_w[0], 0);
        chk("rst/busy", busy_w[0], 0);
        chk("rst/strobes", {reg_rd_w[0], reg_wr_w[0], frame_err_w[0]}, 0);
        chk("rst/np_busy", busy_w[1], 0);
        rst_n = 1'b1;
        repeat (4) @(negedge mdc);

        run(3, 32, 0, 2'b01, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0000, "read_a5c3");
        run(3, 32, 0, 2'b01, 2'b01, 5'd1, 5'd5, 2'b10, 16'h1234, "write_1234");
        run(3, 32, 0, 2'b01, 2'b10, 5'd3, 5'd2, 2'b00, 16'h0000, "read_other_phy");
        run(3, 32, 0, 2'b01, 2'b10, 5'd1, 5'd9, 2'b00, 16'h0000, "read_after_skip");
        run(3, 0, 0, 2'b01, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0000, "no_preamble");
        run(1, 31, 1, 2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'hBEEF, "short_preamble");
        run(1, 32, 0, 2'b00, 2'b01, 5'd1, 5'd4, 2'b10, 16'h0F0F, "bad_st");
        run(1, 32, 0, 2'b01, 2'b11, 5'd1, 5'd4, 2'b10, 16'h0F0F, "bad_op");
        run(1, 32, 0, 2'b01, 2'b01, 5'd1, 5'd4, 2'b11, 16'h0F0F, "bad_ta");
        run(3, 80, 0, 2'b01, 2'b01, 5'd0, 5'd6, 2'b10, 16'hC0DE, "bcast_write");
        run(3, 32, 0, 2'b01, 2'b10, 5'd0, 5'd6, 2'b00, 16'h0000, "bcast_read");

        for (int k = 0; k < 10; k++) begin
            op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            sel = $urandom_range(0, 3);
            pa = (sel == 0) ? 5'd0 : (sel == 1) ? 5'($urandom) : 5'd1;
            run(3, 32 + $urandom_range(0, 3), 0, 2'b01, op, pa, 5'($urandom), 2'b10,
                16'($urandom), "rnd");
        end

        // abort a read while data bit 7 is on the line
        send_frame(32, 0, 2'b01, 2'b10, 5'd1, 5'd7, 2'b00, 16'h0000, 10);
        chk("abort/oe_before", mdio_oe_w[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort/oe_async", mdio_oe_w[0], 0);
        chk("abort/busy", busy_w[0], 0);
        chk("abort/mdio_o", mdio_o_w[0], 0);
        repeat (3) @(negedge mdc);
        rst_n = 1'b1;
        run(3, 32, 0, 2'b01, 2'b10, 5'd1, 5'd7, 2'b00, 16'h0000, "read_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side responder for IEEE 802.3 Clause 22 management frames, i.e. the counterpart of our MDIO station-management master.
- Decodes preamble, ST, OP, PHYAD, REGAD, TA and DATA fields on the MDIO line.
- Serves reads and writes through a simple local register-bank port.
- Used to emulate a PHY management interface on the FPGA side and as a loop-back target for the management master.

Parameters:
- PRE_LEN, 32: consecutive preamble ones required before ST is accepted; 0 = preamble suppression allowed.
- BCAST_EN, 0: 1 = PHYAD 5'd0 also matches, for writes only.

Ports:
- mdc  input  1  management clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- phy_addr  input  5  this responder's PHY address; sampled when the PHYAD field completes
- mdio_i  input  1  MDIO line input, sampled on rising mdc
- mdio_o  output  1  MDIO drive value
- mdio_oe  output  1  1 = responder drives MDIO (external tristate: mdio = oe ? o : Z)
- reg_addr  output  5  register address of the current frame
- reg_rd  output  1  one-cycle read strobe
- reg_rdata  input  16  register read data; must be valid the cycle after reg_rd
- reg_wr  output  1  one-cycle write strobe
- reg_wdata  output  16  write data
- busy  output  1  frame in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE; preamble counter=0; all outputs 0 (mdio_o=0, mdio_oe=0, reg_addr=0, reg_wdata=0). Reset mid-frame aborts immediately: mdio_oe drops asynchronously and no strobe is issued.
- States: IDLE, ST2, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP. A 5-bit bit counter serves the multi-bit states.
- IDLE:
  - mdio_i=1: increment the preamble counter, saturating at 63.
  - mdio_i=0 with count>=PRE_LEN: go to ST2.
  - mdio_i=0 otherwise: clear the counter and stay.
- ST2: sample 1 -> OP. Sample 0 -> frame_err pulse, counter=0, IDLE.
- OP: two bits. 10 = read, 01 = write. 00 or 11 -> frame_err, IDLE.
- PHYAD: five bits, MSB first. Match = (addr==phy_addr), or (BCAST_EN && addr==0 && op==write).
- REGAD: five bits. reg_addr is updated on the edge sampling the last bit, for matched frames only.
- Edge sampling the last REGAD bit:
  - No match: go to SKIP.
  - Matched read: reg_rd=1 for one cycle, go to TA.
  - Matched write: go to TA.
- Read turnaround and data:
  - TA read, edge sampling TA bit 1: capture reg_rdata into the shift register; set mdio_oe=1, mdio_o=0 (TA bit 2 slot); go to RDATA.
  - RDATA: on each of 16 edges, mdio_o = shift[15], then shift left. The first RDATA edge drives bit 15.
  - On the edge after bit 0 has been driven for one full period: mdio_oe=0, go to IDLE.
  - mdio_oe is high for exactly 17 consecutive mdc cycles.
  - The responder never drives outside this window.
- Write turnaround and data:
  - TA write: two bits, required 1 then 0; mismatch -> frame_err, IDLE.
  - WDATA: 16 bits shifted in MSB first.
  - Edge sampling bit 0: reg_wdata updated and reg_wr=1 for one cycle; go to IDLE.
- SKIP: counts the remaining 18 bit times (TA + DATA) with mdio_oe=0 and no strobes, then goes to IDLE. A read to another PHY is therefore never answered.
- After any frame, the preamble counter restarts from 0. Back-to-back frames need a fresh PRE_LEN ones unless PRE_LEN=0.
- PRE_LEN=0: a single 0 in IDLE is accepted as the first ST bit.
- Strobes: reg_rd and reg_wr never assert together and never in the same frame.
- Error pulse: frame_err never coincides with a strobe.

Test Plan:
- phy_addr=5'd1; 32 ones; read frame PHYAD=1, REGAD=2; reg_rdata=16'hA5C3 -> reg_rd one pulse with reg_addr=2; mdio_oe high 17 cycles; mdio_o = 0 then serial 1010010111000011.
- 32 ones; write PHYAD=1, REGAD=5, TA=10, data 16'h1234 -> single reg_wr pulse, reg_wdata=16'h1234, reg_addr=5; mdio_oe never asserted.
- Read frame with PHYAD=3 (phy_addr=1) -> no reg_rd, mdio_oe stays 0 through the frame; next valid frame is answered correctly.
- Only 31 preamble ones then 01 -> frame ignored: no strobe, busy stays 0. PRE_LEN=0 build: no preamble -> frame accepted.
- Bad fields, each -> one frame_err pulse, no strobe, IDLE:
  - ST=00
  - OP=11
  - write with TA=11
- rst_n pulled low during RDATA bit 7 -> mdio_oe=0 immediately, busy=0; after release, a full read returns correct data.
